// File: rtl/byte_striping_pkg.sv
// Definitions shared by the byte-striping and byte-unstriping stages.
// Lane indices and word geometry live here so both ends agree on lane order.
package byte_striping_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 2;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Lanes are consumed strictly alternately, so the successor is simply the other lane.
  function automatic lane_e next_lane(input lane_e cur);
    return (cur == LANE0) ? LANE1 : LANE0;
  endfunction

endpackage

// File: rtl/byte_unstriping_lane_fifo.sv
// Per-lane elastic buffer: circular FIFO with a show-ahead head word.
// Pushes into a full FIFO are accepted only when a pop frees a slot on the same edge.
module lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk_2f) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/byte_unstriping.sv
// Recombines the two striped lanes into one in-order word stream.
// Lane 0 carries even-position words, lane 1 odd-position words; lanes are never skipped.
module byte_unstriping
  import byte_striping_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_in1,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             err_overflow
);

  lane_e            sel;
  logic [WIDTH-1:0] head0;
  logic [WIDTH-1:0] head1;
  logic [WIDTH-1:0] head;
  logic             full0;
  logic             full1;
  logic             empty0;
  logic             empty1;
  logic             head_empty;
  logic             out_free;
  logic             load;
  logic             pop0;
  logic             pop1;
  logic             drop;

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .push   (valid_in0),
    .pop    (pop0),
    .din    (lane_0),
    .dout   (head0),
    .full   (full0),
    .empty  (empty0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .push   (valid_in1),
    .pop    (pop1),
    .din    (lane_1),
    .dout   (head1),
    .full   (full1),
    .empty  (empty1)
  );

  // Handshake: a word transfers at an edge where valid_out=1 and ready_in=1. While
  // valid_out=1 and ready_in=0 the output register is frozen. The register may refill
  // on the same edge it is drained, giving one word per cycle.
  assign head       = (sel == LANE0) ? head0 : head1;
  assign head_empty = (sel == LANE0) ? empty0 : empty1;
  assign out_free   = ~valid_out | ready_in;
  assign load       = out_free & ~head_empty;
  assign pop0       = load & (sel == LANE0);
  assign pop1       = load & (sel == LANE1);

  // A push is lost only when its FIFO is full and not being popped on the same edge.
  assign drop = (valid_in0 & full0 & ~pop0) | (valid_in1 & full1 & ~pop1);

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      sel       <= LANE0;
    end else if (load) begin
      data_out  <= head;
      valid_out <= 1'b1;
      sel       <= next_lane(sel);
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      err_overflow <= 1'b0;
    end else if (drop) begin
      err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Testbench for byte_unstriping: directed scenarios plus random traffic, scored
// against a queue-based model of the two lane buffers and the alternating reader.
module tb_byte_unstriping;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk_2f = 1'b0;
  logic         reset  = 1'b1;
  logic [W-1:0] lane_0 = '0;
  logic         valid_in0 = 1'b0;
  logic [W-1:0] lane_1 = '0;
  logic         valid_in1 = 1'b0;
  logic         ready_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         err_overflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] seen_q[$];

  // Reference model state: lane queues hold accepted words, in arrival order.
  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];
  bit           m_sel;
  bit           m_vo;
  bit           m_err;
  logic [W-1:0] m_dout;

  byte_unstriping #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .lane_0       (lane_0),
    .valid_in0    (valid_in0),
    .lane_1       (lane_1),
    .valid_in1    (valid_in1),
    .ready_in     (ready_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .err_overflow (err_overflow)
  );

  // ---------------- clock ----------------
  always #5 clk_2f = ~clk_2f;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Next word comes from the lane named by m_sel; the output register takes it when free.
  always @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      mq0.delete();
      mq1.delete();
      exp_q.delete();
      m_sel  = 1'b0;
      m_vo   = 1'b0;
      m_err  = 1'b0;
      m_dout = '0;
    end else begin
      bit           have;
      logic [W-1:0] w;
      have = m_sel ? (mq1.size() != 0) : (mq0.size() != 0);
      if ((!m_vo || ready_in) && have) begin
        w = m_sel ? mq1.pop_front() : mq0.pop_front();
        m_dout = w;
        m_vo   = 1'b1;
        m_sel  = !m_sel;
        exp_q.push_back(w);
      end else if (m_vo && ready_in) begin
        m_vo = 1'b0;
      end
      // Popping first means a full lane popped this edge has room for the new word.
      if (valid_in0) begin
        if (mq0.size() < DEPTH) mq0.push_back(lane_0);
        else m_err = 1'b1;
      end
      if (valid_in1) begin
        if (mq1.size() < DEPTH) mq1.push_back(lane_1);
        else m_err = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_2f) begin
    if (!reset) begin
      check("valid_out", {31'b0, valid_out}, {31'b0, m_vo});
      check("err_overflow", {31'b0, err_overflow}, {31'b0, m_err});
      check("data_out_reg", data_out, m_dout);
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL handshake: got %h expected nothing (queue empty)", data_out);
        end else begin
          check("handshake", data_out, exp_q.pop_front());
        end
        seen_q.push_back(data_out);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v0, input logic [W-1:0] d0,
                      input bit v1, input logic [W-1:0] d1, input bit rdy);
    valid_in0 = v0;
    lane_0    = d0;
    valid_in1 = v1;
    lane_1    = d1;
    ready_in  = rdy;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    logic [W-1:0] basic_exp [4];
    basic_exp[0] = 32'hFFFFFFFF;
    basic_exp[1] = 32'hEEEEEEEE;
    basic_exp[2] = 32'hDDDDDDDD;
    basic_exp[3] = 32'hCCCCCCCC;

    // Reset state
    repeat (2) @(posedge clk_2f);
    #1;
    check("reset_data_out", data_out, '0);
    check("reset_valid_out", {31'b0, valid_out}, 32'd0);
    check("reset_err", {31'b0, err_overflow}, 32'd0);
    reset = 1'b0;

    // Basic order
    seen_q.delete();
    step(1'b1, 32'hFFFFFFFF, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1, 32'hEEEEEEEE, 1'b1);
    step(1'b1, 32'hDDDDDDDD, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1, 32'hCCCCCCCC, 1'b1);
    idle(4, 1'b1);
    check("basic_count", seen_q.size(), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) check("basic_word", seen_q[i], basic_exp[i]);

    // Lane skew: lane 1 arrives two cycles early
    seen_q.delete();
    step(1'b0, '0, 1'b1, 32'h00000004, 1'b1);
    idle(2, 1'b1);
    check("skew_held", {31'b0, valid_out}, 32'd0);
    step(1'b1, 32'h00000003, 1'b0, '0, 1'b1);
    idle(4, 1'b1);
    check("skew_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("skew_first", seen_q[0], 32'h00000003);
      check("skew_second", seen_q[1], 32'h00000004);
    end

    // Back-pressure
    step(1'b1, 32'hAAAAAAAA, 1'b1, 32'h99999999, 1'b0);
    idle(3, 1'b0);
    check("bp_hold_data", data_out, 32'hAAAAAAAA);
    check("bp_hold_valid", {31'b0, valid_out}, 32'd1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("bp_next", data_out, 32'h99999999);
    idle(3, 1'b1);

    // Overflow: five lane-1 pushes with lane 0 silent
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 32'hB0000000 + i, 1'b0);
    check("ovf_flag", {31'b0, err_overflow}, 32'd1);
    seen_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0000000 + i, 1'b0, '0, 1'b1);
    idle(6, 1'b1);
    check("ovf_count", seen_q.size(), 8);
    if (seen_q.size() == 8) begin
      check("ovf_last", seen_q[7], 32'hB0000003);
    end

    // Reset mid-stream with sel pointing at lane 1 and lane-1 words buffered
    step(1'b1, 32'h55555555, 1'b1, 32'h66666666, 1'b0);
    step(1'b0, '0, 1'b1, 32'h77777777, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_data", data_out, '0);
    check("mid_reset_valid", {31'b0, valid_out}, 32'd0);
    check("mid_reset_err", {31'b0, err_overflow}, 32'd0);
    @(posedge clk_2f);
    #1 reset = 1'b0;
    seen_q.delete();
    step(1'b0, '0, 1'b1, 32'h11111111, 1'b1);
    step(1'b1, 32'h22222222, 1'b0, '0, 1'b1);
    idle(4, 1'b1);
    check("post_reset_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("post_reset_first", seen_q[0], 32'h22222222);
      check("post_reset_second", seen_q[1], 32'h11111111);
    end

    // Full lane-0 FIFO pushed on the same edge it is popped
    step(1'b1, 32'hC0000000, 1'b0, '0, 1'b0);
    for (int i = 1; i < 5; i++) step(1'b1, 32'hC0000000 + i, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 32'hD0000000, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b1, 32'hC0000005, 1'b0, '0, 1'b1);
    check("full_pp_err", {31'b0, err_overflow}, 32'd0);
    for (int i = 1; i < 6; i++) step(1'b0, '0, 1'b1, 32'hD0000000 + i, 1'b1);
    idle(6, 1'b1);
    check("full_pp_err_end", {31'b0, err_overflow}, 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 45, $urandom,
           $urandom_range(0, 3) != 0);
    end
    idle(30, 1'b1);
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_unstriping.md
# byte_unstriping

Receive-side counterpart of the byte-striping stage: it takes the two lanes produced by striping and recombines them into one in-order 32-bit word stream. Words are consumed strictly alternating lane 0, lane 1, lane 0, … with a small per-lane elastic buffer to absorb lane skew. It drives a registered output with valid/ready flow control. It sits directly downstream of the striping stage, after lane transport, and feeds the word-level consumer.

## Interface
- `WIDTH`, 32, word width of each lane and of the output.
- `DEPTH`, 4, entries per lane FIFO; power of two, ≥ 2.
- `clk_2f` in 1 — single clock; every register updates on its rising edge.
- `reset` in 1 — asynchronous, active-high.
- `lane_0` in WIDTH — lane 0 word, carrying even-position words.
- `valid_in0` in 1 — `lane_0` carries a word this cycle.
- `lane_1` in WIDTH — lane 1 word, carrying odd-position words.
- `valid_in1` in 1 — `lane_1` carries a word this cycle.
- `ready_in` in 1 — downstream accepts `data_out` this cycle.
- `data_out` out WIDTH — recombined word, registered.
- `valid_out` out 1 — `data_out` holds a word, registered.
- `err_overflow` out 1 — sticky flag: a lane word was dropped because its FIFO was full.

## Operation
- **Lane buffering**
  - Each lane has its own FIFO of `DEPTH` entries.
  - `valid_inN` high at an edge pushes `lane_N`.
- **Read pointer `sel`**
  - 1-bit register, reset to 0.
  - Names the lane whose word must be emitted next.
- **Load condition (`load`)**
  - `load` = (`valid_out`==0 or `ready_in`==1) and FIFO[`sel`] non-empty.
  - On `load`: pop FIFO[`sel`] into `data_out`, set `valid_out`=1, toggle `sel`.
- **Drain without load**
  - When `valid_out`==1, `ready_in`==1 and there is no `load`, `valid_out` goes to 0.
  - `data_out` keeps its last value.
- **Stall**
  - When `valid_out`==1 and `ready_in`==0, `data_out`/`valid_out` hold unchanged.
- **Strict ordering**
  - If FIFO[`sel`] is empty, nothing is emitted, even if the other lane holds words. Lanes are never skipped.
- **Overflow**
  - A push to a FIFO that is full and not popped in the same cycle is dropped.
  - The dropped push sets `err_overflow`=1; the flag clears only on `reset`.
- **Full FIFO, simultaneous push and pop**
  - Both are performed; the count is unchanged and no error is raised.
- **Empty FIFO, simultaneous push and pop**
  - Not possible: a pop needs a non-empty FIFO before the edge, so there is no bypass path.
- **Arithmetic**
  - FIFO pointers are log2(`DEPTH`) bits, wrapping modulo `DEPTH`.
  - Count is log2(`DEPTH`)+1 bits.
  - full = (count == `DEPTH`), empty = (count == 0).
- **Reset values** (asynchronous, any time including mid-stream)
  - `data_out`=0, `valid_out`=0, `err_overflow`=0, `sel`=0.
  - Both FIFOs' pointers and counts = 0; buffered words are discarded.
  - First word after reset is taken from lane 0.

## Timing
- **Latency**
  - A word pushed at edge k is eligible for `load` at edge k+1.
  - It appears on `data_out`/`valid_out` after edge k+1 when the output is free and it is next in order.
  - Minimum latency is therefore 2 edges from `valid_in` sampling to `data_out` valid.
- **Throughput**: one word per `clk_2f` cycle while both lanes keep up and `ready_in`=1.
- **Handshake**: a transfer occurs at an edge where `valid_out`=1 and `ready_in`=1.
- **Output stability**: `data_out` does not change while `valid_out`=1 and `ready_in`=0.
- **Independent inputs**: `valid_in0` and `valid_in1` may be asserted in the same or in different cycles; skew of up to `DEPTH` words between lanes is absorbed.

## Structure
- **Shared package `byte_striping_pkg`**
  - `WORD_W` = 32.
  - `LANES` = 2.
  - Lane-index typedef (`LANE0`, `LANE1`) used by both striping and un-striping.
- **Sub-module `lane_fifo`** (parameters `WIDTH`, `DEPTH`)
  - Ports: push, pop, data in/out, full, empty.
  - Async active-high reset.
  - Instantiated twice.
- **Top level**: `sel`, the output register, load logic and `err_overflow`.

## Test plan
- **Basic order.** Reset, then:
  - Stimulus: lane_0=FFFFFFFF at edge 1; lane_1=EEEEEEEE at edge 2; lane_0=DDDDDDDD at edge 3; lane_1=CCCCCCCC at edge 4; `ready_in`=1.
  - Required: `data_out` = FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on consecutive cycles starting after edge 2.
- **Lane skew.**
  - Stimulus: lane_1 sends 00000004 two cycles before lane_0 sends 00000003.
  - Required: `valid_out` stays 0 until 00000003 is emitted, then 00000004 the next cycle.
- **Back-pressure.**
  - Stimulus: AAAAAAAA, 99999999 queued; `ready_in`=0 for 3 cycles.
  - Required: `data_out`=AAAAAAAA held with `valid_out`=1; 99999999 follows one cycle after `ready_in` rises.
- **Overflow.**
  - Stimulus: `ready_in`=0, lane_1 pushed 5 times with `DEPTH`=4 while lane_0 is silent.
  - Required: `err_overflow`=1 after the 5th push; 4 words are retained and emitted in order once lane_0 supplies words.
- **Full push+pop.**
  - Stimulus: lane_0 FIFO full, pushed on the same edge it is popped.
  - Required: no error, count unchanged, order preserved.
- **Reset mid-stream.**
  - Stimulus: `reset` asserted asynchronously with words buffered and `sel`=1.
  - Required: outputs are 0 immediately; after release, the first word is taken from lane 0.
